// File: rtl/handshake_protocol_monitor_pkg.sv
// rtl/handshake_protocol_monitor_pkg.sv - shared types and helpers for the ready/valid handshake monitor
package handshake_protocol_monitor_pkg;

    typedef enum logic {
        HS_IDLE  = 1'b0,
        HS_STALL = 1'b1
    } hs_state_e;

    typedef struct packed {
        logic drop;
        logic data;
        logic timeout;
    } hs_err_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
        return (value >= max_value) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/handshake_protocol_monitor_hs_channel_checker.sv
// rtl/handshake_protocol_monitor_hs_channel_checker.sv - one ready/valid channel: FSM, shadow, stall and transfer counters, sticky errors
module hs_channel_checker
    import handshake_protocol_monitor_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              valid,
    input  logic              ready,
    input  logic [DATA_W-1:0] data,
    input  logic              clr,
    output logic [CNT_W-1:0]  xfer_cnt,
    output hs_err_t           err,
    output logic              err_any_nxt
);

    // Stall counter is wide enough to pass TIMEOUT and then saturate above it,
    // so the equality test that raises err_timeout can match only once per stall.
    localparam int SC_W = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    hs_state_e         state;
    logic [DATA_W-1:0] shadow;
    logic [SC_W-1:0]   stall_q;
    logic [SC_W-1:0]   stall_d;
    logic [CNT_W-1:0]  xfer_q;
    hs_err_t           err_q;
    hs_err_t           set;
    hs_err_t           err_nxt;
    logic              stall_hold;

    always_comb begin
        stall_hold = valid && !ready;
        stall_d    = '0;
        if (stall_hold) begin
            if (state == HS_IDLE)
                stall_d = SC_W'(1);
            else if (stall_q == {SC_W{1'b1}})
                stall_d = stall_q;
            else
                stall_d = stall_q + 1'b1;
        end

        set = '0;
        if (state == HS_STALL) begin
            set.drop = !valid;
            set.data = valid && (data != shadow);
        end
        set.timeout = (TIMEOUT != 0) && stall_hold && (stall_d == SC_W'(TIMEOUT));

        // A set in the same cycle as clr wins over the clear.
        err_nxt     = (clr ? hs_err_t'('0) : err_q) | set;
        err_any_nxt = |err_nxt;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state   <= HS_IDLE;
            shadow  <= '0;
            stall_q <= '0;
            xfer_q  <= '0;
            err_q   <= '0;
        end else begin
            err_q   <= err_nxt;
            stall_q <= stall_d;

            if (valid && ready)
                xfer_q <= clr ? CNT_W'(1) : CNT_W'(sat_inc(32'(xfer_q), 32'(CNT_MAX)));
            else if (clr)
                xfer_q <= '0;

            case (state)
                HS_IDLE: begin
                    if (stall_hold) begin
                        state  <= HS_STALL;
                        shadow <= data;
                    end
                end
                HS_STALL: begin
                    if (!stall_hold)
                        state <= HS_IDLE;
                end
                default: state <= HS_IDLE;
            endcase
        end
    end

    assign xfer_cnt = xfer_q;
    assign err      = err_q;

endmodule

// File: rtl/handshake_protocol_monitor.sv
// rtl/handshake_protocol_monitor.sv - NUM_CH-channel ready/valid protocol monitor; HANDSHAKE_PROTOCOL_MONITOR_ASSERT_EN adds SVA checks
module handshake_protocol_monitor
    import handshake_protocol_monitor_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic [NUM_CH-1:0]        valid,
    input  logic [NUM_CH-1:0]        ready,
    input  logic [NUM_CH*DATA_W-1:0] data,
    input  logic                     clr,
    output logic [NUM_CH*CNT_W-1:0]  xfer_cnt,
    output logic [NUM_CH-1:0]        err_drop,
    output logic [NUM_CH-1:0]        err_data,
    output logic [NUM_CH-1:0]        err_timeout,
    output logic                     err_any
);

    hs_err_t           err_ch [NUM_CH];
    logic [NUM_CH-1:0] any_nxt;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        hs_channel_checker #(
            .DATA_W  (DATA_W),
            .CNT_W   (CNT_W),
            .TIMEOUT (TIMEOUT)
        ) u_chk (
            .CLK         (CLK),
            .RESETN      (RESETN),
            .valid       (valid[i]),
            .ready       (ready[i]),
            .data        (data[i*DATA_W +: DATA_W]),
            .clr         (clr),
            .xfer_cnt    (xfer_cnt[i*CNT_W +: CNT_W]),
            .err         (err_ch[i]),
            .err_any_nxt (any_nxt[i])
        );

        assign err_drop[i]    = err_ch[i].drop;
        assign err_data[i]    = err_ch[i].data;
        assign err_timeout[i] = err_ch[i].timeout;

`ifdef HANDSHAKE_PROTOCOL_MONITOR_ASSERT_EN
        a_hold_valid: assert property (@(posedge CLK) disable iff (!RESETN)
            valid[i] && !ready[i] |=> valid[i])
            else $error("hs ch%0d: valid dropped while stalled", i);
        a_hold_data: assert property (@(posedge CLK) disable iff (!RESETN)
            valid[i] && !ready[i] |=> $stable(data[i*DATA_W +: DATA_W]))
            else $error("hs ch%0d: data changed while stalled", i);
        a_rise_drop: assert property (@(posedge CLK) disable iff (!RESETN) !$rose(err_drop[i]))
            else $error("hs ch%0d: err_drop raised", i);
        a_rise_data: assert property (@(posedge CLK) disable iff (!RESETN) !$rose(err_data[i]))
            else $error("hs ch%0d: err_data raised", i);
        a_rise_timeout: assert property (@(posedge CLK) disable iff (!RESETN) !$rose(err_timeout[i]))
            else $error("hs ch%0d: err_timeout raised", i);
`endif
    end

    // Registered from the channels' next-state errors so it lines up with the error bits.
    always_ff @(posedge CLK) begin
        if (!RESETN)
            err_any <= 1'b0;
        else
            err_any <= |any_nxt;
    end

endmodule
